// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative signed divider (restoring shift-subtract, one quotient bit per
// cycle) with sign correction and a one-cycle ready pulse.  Its result, ready
// and exception handshake matches the multiply datapath in the multdiv unit.
//
// Optional feature macro: DIV_REMAINDER_EN
//   When defined, the data_remainder port and its sign-correction logic exist.
//   When undefined, the port is absent.  The partial remainder is still kept
//   internally because the algorithm needs it.
//
// Ports
//   clock           in   rising-edge clock
//   reset           in   asynchronous active-low reset
//   ctrl_DIV        in   start strobe (also aborts/restarts a running op)
//   data_operandA   in   dividend, two's complement
//   data_operandB   in   divisor, two's complement
//   data_result     out  quotient, truncated toward zero (held until next start)
//   data_exception  out  divide-by-zero flag, valid while data_resultRDY=1
//   data_resultRDY  out  one-cycle completion pulse
//   busy            out  high from accept edge until the edge raising ready
//   data_remainder  out  remainder, sign follows dividend (DIV_REMAINDER_EN)
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
`ifdef DIV_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] data_remainder
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_e;

    // Two's complement negation modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
        neg_f = ~v + WIDTH'(1);
    endfunction

    // Magnitude as an unsigned WIDTH-bit value; the most negative value maps
    // onto itself, which is exactly its magnitude when read as unsigned.
    function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            abs_f = neg_f(v);
        end else begin
            abs_f = v;
        end
    endfunction

    state_e             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   q_q;        // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0]   r_q;        // partial remainder; always < |B| so the top bit of R is 0
    logic [WIDTH-1:0]   b_q;        // divisor magnitude
    logic               qs_q;       // quotient sign
    logic [WIDTH-1:0]   result_q;
    logic               exc_q;
    logic               rdy_q;
    logic               busy_q;
`ifdef DIV_REMAINDER_EN
    logic               rs_q;       // remainder sign (follows dividend)
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   rem_signed_s;
`endif

    logic [WIDTH:0]     r_sh_s;     // shifted partial remainder, WIDTH+1 bits
    logic [WIDTH:0]     t_s;        // trial difference, WIDTH+1 bits
    logic [WIDTH-1:0]   r_step_d;
    logic [WIDTH-1:0]   q_step_d;
    logic [WIDTH-1:0]   q_signed_s;

    // One restoring iteration: shift {R,Q} left, trial-subtract |B|, keep or restore.
    always_comb begin
        r_sh_s = {r_q, q_q[WIDTH-1]};
        t_s    = r_sh_s - {1'b0, b_q};
        if (!t_s[WIDTH]) begin
            r_step_d = t_s[WIDTH-1:0];
            q_step_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            r_step_d = r_sh_s[WIDTH-1:0];
            q_step_d = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction of the finished magnitudes.
    always_comb begin
        if (qs_q) begin
            q_signed_s = neg_f(q_q);
        end else begin
            q_signed_s = q_q;
        end
`ifdef DIV_REMAINDER_EN
        if (rs_q) begin
            rem_signed_s = neg_f(r_q);
        end else begin
            rem_signed_s = r_q;
        end
`endif
    end

    // Control FSM with registered datapath and outputs.  A start strobe wins
    // in every state, so it both launches and aborts operations.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= {CNT_W{1'b0}};
            q_q      <= {WIDTH{1'b0}};
            r_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            qs_q     <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef DIV_REMAINDER_EN
            rs_q     <= 1'b0;
            rem_q    <= {WIDTH{1'b0}};
`endif
        end else if (ctrl_DIV) begin
            q_q     <= abs_f(data_operandA);
            b_q     <= abs_f(data_operandB);
            r_q     <= {WIDTH{1'b0}};
            count_q <= {CNT_W{1'b0}};
            qs_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            busy_q  <= 1'b1;
            rdy_q   <= 1'b0;     // an aborted operation never pulses ready
`ifdef DIV_REMAINDER_EN
            rs_q    <= data_operandA[WIDTH-1];
`endif
            if (data_operandB == {WIDTH{1'b0}}) begin
                // Divide by zero: publish the outcome now; DONE raises ready next edge.
                state_q  <= DONE;
                exc_q    <= 1'b1;
                result_q <= {WIDTH{1'b0}};
`ifdef DIV_REMAINDER_EN
                rem_q    <= data_operandA;
`endif
            end else begin
                state_q <= RUN;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    rdy_q  <= 1'b0;
                end
                RUN: begin
                    r_q     <= r_step_d;
                    q_q     <= q_step_d;
                    count_q <= count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= SIGN;
                    end else begin
                        state_q <= RUN;
                    end
                end
                SIGN: begin
                    result_q <= q_signed_s;
                    exc_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
                    rem_q    <= rem_signed_s;
`endif
                    rdy_q    <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= DONE;
                end
                DONE: begin
                    // Entered with ready low only on the divide-by-zero path.
                    if (rdy_q) begin
                        rdy_q   <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        rdy_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;
`ifdef DIV_REMAINDER_EN
    assign data_remainder = rem_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider: directed cases, randomized operands
// against a signed-arithmetic reference, abort, back-to-back, held start and
// mid-operation reset.  Remainder checks exist when DIV_REMAINDER_EN is defined.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         ctrl_DIV;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] res;
    logic         exc;
    logic         rdy;
    logic         busy;
    logic [W-1:0] rem;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    seq_divider #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .data_result    (res),
        .data_exception (exc),
        .data_resultRDY (rdy),
        .busy           (busy)
`ifdef DIV_REMAINDER_EN
        ,
        .data_remainder (rem)
`endif
    );

`ifndef DIV_REMAINDER_EN
    assign rem = 32'd0;
`endif

    // Reference: plain signed division (truncating toward zero) in 64 bits.
    function automatic void model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic e);
        longint sa, sb, sq, sr;
        sa = longint'($signed(ai));
        sb = longint'($signed(bi));
        if (bi == 32'd0) begin
            q = 32'd0; r = ai; e = 1'b1;
        end else begin
            sq = sa / sb;
            sr = sa % sb;
            q = sq[W-1:0]; r = sr[W-1:0]; e = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        ctrl_DIV = 1'b1; op_a = a; op_b = b;
        tick();
        ctrl_DIV = 1'b0;
    endtask

    // Counts edges after the accept edge until ready; lat=-1 on timeout.
    task automatic wait_rdy(output int lat, output bit busy_ok);
        lat = -1;
        busy_ok = (busy === 1'b1);
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (rdy === 1'b1) begin
                lat = n;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end else if (busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; ctrl_DIV = 1'b0; op_a = 32'd0; op_b = 32'd0;
        #12;
        n_vec++; if (res !== 32'd0) begin n_err++; $display("FAIL reset_result got %h want %h", res, 32'd0); end
        n_vec++; if (exc !== 1'b0) begin n_err++; $display("FAIL reset_exc got %b want 0", exc); end
        n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy got %b want 0", rdy); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
`ifdef DIV_REMAINDER_EN
        n_vec++; if (rem !== 32'd0) begin n_err++; $display("FAIL reset_rem got %h want 0", rem); end
`endif
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0] da [6] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'd5, 32'd6, 32'h8000_0000};
        logic [W-1:0] db [6] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'd0, 32'd3, 32'hFFFF_FFFF};
        logic [W-1:0] eq [6] = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd0, 32'd2, 32'h8000_0000};
        logic [W-1:0] er [6] = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'd5, 32'd0, 32'd0};
        logic         ee [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int           el [6] = '{33, 33, 33, 1, 33, 33};
        int lat;
        bit bok;
        for (int i = 0; i < 6; i++) begin
            start_op(da[i], db[i]);
            wait_rdy(lat, bok);
            n_vec++; if (lat !== el[i]) begin n_err++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, el[i]); end
            n_vec++; if (res !== eq[i]) begin n_err++; $display("FAIL dir%0d_result got %h want %h", i, res, eq[i]); end
            n_vec++; if (exc !== ee[i]) begin n_err++; $display("FAIL dir%0d_exc got %b want %b", i, exc, ee[i]); end
            n_vec++; if (!bok) begin n_err++; $display("FAIL dir%0d_busy got bad want ok", i); end
`ifdef DIV_REMAINDER_EN
            n_vec++; if (rem !== er[i]) begin n_err++; $display("FAIL dir%0d_rem got %h want %h", i, rem, er[i]); end
`endif
            tick();
            n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL dir%0d_rdy_width got %b want 0", i, rdy); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, eqv, erv;
        logic         eev;
        int lat;
        bit bok;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = 32'd0 - 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            model(a, b, eqv, erv, eev);
            start_op(a, b);
            wait_rdy(lat, bok);
            n_vec++; if (lat !== (eev ? 1 : 33)) begin n_err++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, eev ? 1 : 33); end
            n_vec++; if (res !== eqv) begin n_err++; $display("FAIL rnd%0d_result %h/%h got %h want %h", i, a, b, res, eqv); end
            n_vec++; if (exc !== eev) begin n_err++; $display("FAIL rnd%0d_exc got %b want %b", i, exc, eev); end
            n_vec++; if (!bok) begin n_err++; $display("FAIL rnd%0d_busy got bad want ok", i); end
`ifdef DIV_REMAINDER_EN
            n_vec++; if (rem !== erv) begin n_err++; $display("FAIL rnd%0d_rem %h/%h got %h want %h", i, a, b, rem, erv); end
`endif
            tick();
        end
    endtask

    task automatic test_abort();
        int lat;
        bit bok;
        bit saw = 1'b0;
        start_op(32'd1000, 32'd3);
        for (int n = 1; n <= 9; n++) begin
            tick();
            if (rdy === 1'b1) saw = 1'b1;
        end
        start_op(32'd9, 32'd3);
        wait_rdy(lat, bok);
        n_vec++; if (saw) begin n_err++; $display("FAIL abort_early_rdy got 1 want 0"); end
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL abort_latency got %0d want 33", lat); end
        n_vec++; if (res !== 32'd3) begin n_err++; $display("FAIL abort_result got %h want %h", res, 32'd3); end
        n_vec++; if (exc !== 1'b0) begin n_err++; $display("FAIL abort_exc got %b want 0", exc); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        bit bok;
        start_op(32'd77, 32'hFFFF_FFFB);
        wait_rdy(lat, bok);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL b2b_first_latency got %0d want 33", lat); end
        n_vec++; if (res !== 32'hFFFF_FFF1) begin n_err++; $display("FAIL b2b_first_result got %h want %h", res, 32'hFFFF_FFF1); end
`ifdef DIV_REMAINDER_EN
        n_vec++; if (rem !== 32'd2) begin n_err++; $display("FAIL b2b_first_rem got %h want %h", rem, 32'd2); end
`endif
        start_op(32'hFFFF_FFF7, 32'd2);
        n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL b2b_rdy_drop got %b want 0", rdy); end
        wait_rdy(lat, bok);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL b2b_second_latency got %0d want 33", lat); end
        n_vec++; if (res !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL b2b_second_result got %h want %h", res, 32'hFFFF_FFFC); end
        n_vec++; if (!bok) begin n_err++; $display("FAIL b2b_second_busy got bad want ok"); end
`ifdef DIV_REMAINDER_EN
        n_vec++; if (rem !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL b2b_second_rem got %h want %h", rem, 32'hFFFF_FFFF); end
`endif
        tick();
    endtask

    task automatic test_hold_restart();
        int lat;
        bit bok;
        bit bad = 1'b0;
        ctrl_DIV = 1'b1; op_a = 32'd20; op_b = 32'd4;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (rdy !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        ctrl_DIV = 1'b0;
        n_vec++; if (bad) begin n_err++; $display("FAIL hold_no_result got rdy/busy wrong want rdy=0 busy=1"); end
        wait_rdy(lat, bok);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL hold_release_latency got %0d want 33", lat); end
        n_vec++; if (res !== 32'd5) begin n_err++; $display("FAIL hold_release_result got %h want %h", res, 32'd5); end
    endtask

    task automatic test_reset_mid();
        bit bad = 1'b0;
        start_op(32'd50, 32'd5);
        for (int n = 1; n <= 11; n++) tick();
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        n_vec++; if (res !== 32'd0) begin n_err++; $display("FAIL rstmid_result got %h want 0", res); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL rstmid_rdy got %b want 0", rdy); end
        n_vec++; if (exc !== 1'b0) begin n_err++; $display("FAIL rstmid_exc got %b want 0", exc); end
`ifdef DIV_REMAINDER_EN
        n_vec++; if (rem !== 32'd0) begin n_err++; $display("FAIL rstmid_rem got %h want 0", rem); end
`endif
        tick();
        reset = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (rdy !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_vec++; if (bad) begin n_err++; $display("FAIL rstmid_after_release got activity want idle"); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_back_to_back();
        test_hold_restart();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
